// File: rtl/spi_ms_ctrl.sv
// Byte-wide SPI controller that runs as either master or slave, selected at run time.
// Software programs it through a small SFR port.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   sfraddr_w/sfrwe/spidata_i SFR write port (SPCR, SPIECR, SPCLK, SPDAT, SPSR)
//   sfraddr_r/sfr_data_o      combinational SFR read port
//   spssn_i/spssn_o           requested / driven slave selects (master, active-low)
//   mosio/misoi/scko          master serial out, serial in, serial clock
//   mosii/misoo/scki/ssn      slave serial in, serial out, clock in, select in
//   intspi                    end-of-byte interrupt (SPIF & SPIE)
//   SPC0                      SPCR bit 0
module spi_ms_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sfraddr_w,
  input  logic [2:0] sfraddr_r,
  input  logic       sfrwe,
  input  logic [7:0] spidata_i,
  input  logic [7:0] spssn_i,
  input  logic       mosii,
  input  logic       misoi,
  input  logic       scki,
  input  logic       ssn,
  output logic [7:0] spssn_o,
  output logic [7:0] sfr_data_o,
  output logic       intspi,
  output logic       mosio,
  output logic       misoo,
  output logic       scko,
  output logic       SPC0
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} m_state_e;

  m_state_e   r_state, w_state_next;
  logic       r_spe, r_mstr, r_cpol, r_cpha, r_dord, r_spc0, r_spie;
  logic [2:0] r_spclk;
  logic [7:0] r_tx, r_rx, r_txsh, r_rxsh, r_ssn_o;
  logic       r_spif, r_wcol, r_sck;
  logic [6:0] r_div;
  logic [4:0] r_edge;
  logic [3:0] r_bits;
  logic       r_scki_m1, r_scki_m2, r_scki_d;
  logic       r_ssn_m1, r_ssn_m2, r_ssn_d;
  logic       r_mosi_m1, r_mosi_m2;

  logic       w_m_en, w_s_en, w_s_act, w_s_fall, w_tick, w_m_start, w_m_abort;
  logic       w_s_chg, w_s_lead, w_s_trail, w_smp, w_shf, w_s_last, w_busy, w_in_bit;
  logic [7:0] w_half, w_rx_next;
  logic [6:0] w_div_max;

  function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b,
                                          input logic lsb_first);
    return lsb_first ? {b, v[7:1]} : {v[6:0], b};
  endfunction

  assign w_m_en    = r_spe & r_mstr;
  assign w_s_en    = r_spe & ~r_mstr;
  assign w_s_act   = w_s_en & ~r_ssn_m2;
  assign w_s_fall  = w_s_en & r_ssn_d & ~r_ssn_m2;
  assign w_half    = 8'd1 << r_spclk;
  assign w_div_max = 7'(w_half - 8'd1);
  assign w_tick    = (r_state == StRun) && (r_div == w_div_max);
  // A transfer starts only on the FF -> non-FF transition of the registered selects.
  assign w_m_start = (r_state == StIdle) && w_m_en && (r_ssn_o == 8'hFF) &&
                     (spssn_i != 8'hFF);
  assign w_m_abort = ~w_m_en | (r_ssn_o == 8'hFF);

  // Slave clock edges, classified against CPOL on the synchronized clock.
  assign w_s_chg   = r_scki_m2 ^ r_scki_d;
  assign w_s_lead  = w_s_chg & (r_scki_m2 != r_cpol);
  assign w_s_trail = w_s_chg & (r_scki_m2 == r_cpol);

  // Master and slave share the shift registers; only one mode is active at a time.
  // In CPHA=1 the first leading edge must not shift: the first bit is already on the line.
  always_comb begin
    w_smp = 1'b0;
    w_shf = 1'b0;
    if (w_m_en) begin
      w_smp = w_tick & (r_cpha ? r_edge[0] : ~r_edge[0]);
      w_shf = w_tick & (r_cpha ? (~r_edge[0] & (r_edge != 5'd0)) : r_edge[0]);
    end else if (w_s_act && !w_s_fall) begin
      w_smp = (r_cpha ? w_s_trail : w_s_lead) & (r_bits != 4'd8);
      w_shf = r_cpha ? (w_s_lead & (r_bits != 4'd0)) : w_s_trail;
    end
  end

  assign w_in_bit  = w_m_en ? misoi : r_mosi_m2;
  assign w_rx_next = shift_in(r_rxsh, w_in_bit, r_dord);
  assign w_s_last  = ~w_m_en & w_smp & (r_bits == 4'd7);
  assign w_busy    = (r_state != StIdle) | w_s_act;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_m_start) w_state_next = StRun;
      StRun: begin
        if (w_m_abort) w_state_next = StIdle;
        else if (w_tick && (r_edge == 5'd15)) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_spe, r_mstr, r_cpol, r_cpha, r_dord, r_spc0, r_spie} <= '0;
      r_spclk <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_txsh  <= '0;
      r_rxsh  <= '0;
      r_ssn_o <= 8'hFF;
      r_spif  <= 1'b0;
      r_wcol  <= 1'b0;
      r_sck   <= 1'b0;
      r_div   <= '0;
      r_edge  <= '0;
      r_bits  <= '0;
      {r_scki_m1, r_scki_m2, r_scki_d} <= '0;
      {r_ssn_m1, r_ssn_m2, r_ssn_d}    <= '1;
      {r_mosi_m1, r_mosi_m2}           <= '0;
    end else begin
      {r_scki_m1, r_scki_m2, r_scki_d} <= {scki, r_scki_m1, r_scki_m2};
      {r_ssn_m1, r_ssn_m2, r_ssn_d}    <= {ssn, r_ssn_m1, r_ssn_m2};
      {r_mosi_m1, r_mosi_m2}           <= {mosii, r_mosi_m1};
      r_ssn_o <= w_m_en ? spssn_i : 8'hFF;

      if (sfrwe) begin
        case (sfraddr_w)
          3'd0: {r_spe, r_mstr, r_cpol, r_cpha, r_dord, r_spc0} <=
                  {spidata_i[6], spidata_i[4:0]};
          3'd1: r_spie  <= spidata_i[0];
          3'd2: r_spclk <= spidata_i[2:0];
          3'd3: begin
            if (w_busy) r_wcol <= 1'b1;
            else        r_tx   <= spidata_i;
          end
          3'd4: begin
            r_spif <= 1'b0;
            r_wcol <= 1'b0;
          end
          default: ;
        endcase
      end

      if (w_m_start) begin
        r_txsh <= r_tx;
        r_rxsh <= '0;
        r_div  <= '0;
        r_edge <= '0;
        r_spif <= 1'b0;
        r_wcol <= 1'b0;
      end
      if (r_state == StRun) begin
        if (w_tick) begin
          r_div  <= '0;
          r_sck  <= ~r_sck;
          r_edge <= r_edge + 5'd1;
        end else begin
          r_div <= r_div + 7'd1;
        end
      end
      // Outside an active transfer (including abort) the clock sits at CPOL.
      if (w_state_next != StRun) r_sck <= r_cpol;
      if (r_state == StDone) begin
        r_rx   <= r_rxsh;
        r_spif <= 1'b1;
      end

      if (w_s_fall) begin
        r_txsh <= r_tx;
        r_rxsh <= '0;
        r_bits <= '0;
      end else if (!w_s_act) begin
        r_bits <= '0;
      end

      if (w_smp) begin
        r_rxsh <= w_rx_next;
        if (!w_m_en) r_bits <= r_bits + 4'd1;
      end
      if (w_shf) r_txsh <= shift_in(r_txsh, 1'b0, r_dord);
      if (w_s_last) begin
        r_rx   <= w_rx_next;
        r_spif <= 1'b1;
      end
    end
  end

  always_comb begin
    sfr_data_o = 8'h00;
    case (sfraddr_r)
      3'd0:    sfr_data_o = {1'b0, r_spe, 1'b0, r_mstr, r_cpol, r_cpha, r_dord, r_spc0};
      3'd1:    sfr_data_o = {7'b0, r_spie};
      3'd2:    sfr_data_o = {5'b0, r_spclk};
      3'd3:    sfr_data_o = r_rx;
      3'd4:    sfr_data_o = {r_spif, r_wcol, 6'b0};
      default: sfr_data_o = 8'h00;
    endcase
  end

  assign spssn_o = r_ssn_o;
  assign scko    = r_sck;
  assign mosio   = (r_state != StIdle) ? (r_dord ? r_txsh[0] : r_txsh[7]) : 1'b0;
  assign misoo   = w_s_act ? (r_dord ? r_txsh[0] : r_txsh[7]) : 1'b0;
  assign intspi  = r_spif & r_spie;
  assign SPC0    = r_spc0;

endmodule

// File: tb/tb_spi_ms_ctrl.sv
// Back-to-back master/slave bench. The reference model is the exchange rule itself: after a
// complete byte each side holds the byte the other side had in its TX buffer, and the master
// clock makes 16 edges spaced 2^N clk apart, idling at CPOL.
module tb_spi_ms_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] m_aw, m_ar, s_aw, s_ar;
  logic       m_we, s_we;
  logic [7:0] m_wd, s_wd, m_ssn_i;
  logic [7:0] m_ssn_o, s_ssn_o, m_rd, s_rd;
  logic       m_int, s_int, m_mosi, s_mosi_o, m_miso_o, s_miso, m_sck, s_sck_o;
  logic       m_spc0, s_spc0;

  always #5 clk = ~clk;

  spi_ms_ctrl u_mst (
    .clk(clk), .rst(rst), .sfraddr_w(m_aw), .sfraddr_r(m_ar), .sfrwe(m_we),
    .spidata_i(m_wd), .spssn_i(m_ssn_i), .mosii(1'b0), .misoi(s_miso), .scki(1'b0),
    .ssn(1'b1), .spssn_o(m_ssn_o), .sfr_data_o(m_rd), .intspi(m_int), .mosio(m_mosi),
    .misoo(m_miso_o), .scko(m_sck), .SPC0(m_spc0)
  );

  spi_ms_ctrl u_slv (
    .clk(clk), .rst(rst), .sfraddr_w(s_aw), .sfraddr_r(s_ar), .sfrwe(s_we),
    .spidata_i(s_wd), .spssn_i(8'hFF), .mosii(m_mosi), .misoi(1'b0), .scki(m_sck),
    .ssn(m_ssn_o[0]), .spssn_o(s_ssn_o), .sfr_data_o(s_rd), .intspi(s_int),
    .mosio(s_mosi_o), .misoo(s_miso), .scko(s_sck_o), .SPC0(s_spc0)
  );

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_m_rx = 8'h00;
  logic [7:0] exp_s_rx = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every step leaves the bench 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit slv, input logic [2:0] a, input logic [7:0] d);
    if (slv) begin s_aw = a; s_wd = d; s_we = 1'b1; end
    else     begin m_aw = a; m_wd = d; m_we = 1'b1; end
    cyc(1);
    m_we = 1'b0;
    s_we = 1'b0;
  endtask

  task automatic rd(input bit slv, input logic [2:0] a, output logic [7:0] d);
    if (slv) s_ar = a;
    else     m_ar = a;
    #1;
    d = slv ? s_rd : m_rd;
  endtask

  task automatic setup(input logic [7:0] mcr, input logic [7:0] mtx, input logic [7:0] stx);
    wr(0, 3'd0, mcr);
    wr(1, 3'd0, mcr & 8'hEF);
    wr(0, 3'd3, mtx);
    wr(1, 3'd3, stx);
  endtask

  task automatic xfer(input string tag, input logic [7:0] mcr, input logic [7:0] mtx,
                      input logic [7:0] stx);
    logic [7:0] v;
    logic       prev;
    int         tog, first, last;
    bit         done;
    setup(mcr, mtx, stx);
    wr(1, 3'd4, 8'h00);
    check($sformatf("%s pre-idle sck", tag), m_sck, mcr[3]);
    m_ssn_i = 8'hFE;
    check($sformatf("%s ssn before latch", tag), m_ssn_o, 8'hFF);
    cyc(1);
    check($sformatf("%s ssn after 1 clk", tag), m_ssn_o, 8'hFE);
    prev = m_sck; tog = 0; first = 0; last = 0; done = 1'b0;
    for (int t = 1; t < 400 && !done; t++) begin
      cyc(1);
      if (m_sck !== prev) begin
        tog++;
        if (tog == 1) first = t;
        last = t;
        prev = m_sck;
      end
      if (m_int) done = 1'b1;
    end
    check($sformatf("%s master done", tag), done, 1'b1);
    check($sformatf("%s sck edges", tag), tog, 16);
    check($sformatf("%s sck span", tag), last - first, 15 * 8);
    check($sformatf("%s sck idle", tag), m_sck, mcr[3]);
    for (int t = 0; t < 20 && !s_int; t++) cyc(1);
    check($sformatf("%s slave int", tag), s_int, 1'b1);
    exp_m_rx = stx;
    exp_s_rx = mtx;
    rd(0, 3'd3, v); check($sformatf("%s master rx", tag), v, exp_m_rx);
    rd(1, 3'd3, v); check($sformatf("%s slave rx", tag), v, exp_s_rx);
    rd(0, 3'd4, v); check($sformatf("%s master spsr", tag), v, 8'h80);
    m_ssn_i = 8'hFF;
    cyc(4);
    check($sformatf("%s mosio idle", tag), m_mosi, 1'b0);
    check($sformatf("%s misoo idle", tag), s_miso, 1'b0);
  endtask

  logic [7:0] modes [8] = '{8'h50, 8'h52, 8'h54, 8'h56, 8'h58, 8'h5A, 8'h5C, 8'h5E};

  initial begin
    logic [7:0] v;
    rst = 1'b1; m_we = 1'b0; s_we = 1'b0;
    m_aw = '0; m_ar = '0; s_aw = '0; s_ar = '0; m_wd = '0; s_wd = '0;
    m_ssn_i = 8'hFF;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    check("rst spssn_o", m_ssn_o, 8'hFF);
    check("rst slave spssn_o", s_ssn_o, 8'hFF);
    check("rst scko", m_sck, 1'b0);
    check("rst slave scko", s_sck_o, 1'b0);
    check("rst outs", {m_mosi, m_miso_o, s_mosi_o, s_miso, m_int, s_int, m_spc0, s_spc0}, 8'h00);
    rd(0, 3'd0, v); check("rst spcr", v, 8'h00);
    rd(0, 3'd4, v); check("rst spsr", v, 8'h00);

    cyc(1);
    wr(0, 3'd0, 8'h5E); wr(0, 3'd1, 8'h01); wr(0, 3'd2, 8'h03);
    rd(0, 3'd0, v); check("reg spcr", v, 8'h5E);
    rd(0, 3'd1, v); check("reg spiecr", v, 8'h01);
    rd(0, 3'd2, v); check("reg spclk", v, 8'h03);
    check("reg spc0 low", m_spc0, 1'b0);
    cyc(1);
    wr(0, 3'd0, 8'h51);
    check("reg spc0 high", m_spc0, 1'b1);
    wr(0, 3'd0, 8'hFF);
    rd(0, 3'd0, v); check("reg reserved bits", v, 8'h5F);
    cyc(1);
    wr(0, 3'd5, 8'hFF);
    rd(0, 3'd5, v); check("reg addr5", v, 8'h00);
    cyc(1);
    wr(1, 3'd1, 8'h01);
    wr(1, 3'd2, 8'h03);

    xfer("mode0 A5/3C", 8'h50, 8'hA5, 8'h3C);

    foreach (modes[i]) begin
      for (int k = 0; k < 20; k++) begin
        xfer($sformatf("mode %0h #%0d", modes[i], k), modes[i], 8'($urandom), 8'($urandom));
      end
    end

    // Collision: SPDAT write during a master transfer.
    setup(8'h50, 8'h96, 8'h69);
    wr(1, 3'd4, 8'h00);
    m_ssn_i = 8'hFE;
    cyc(40);
    wr(0, 3'd3, 8'hFF);
    rd(0, 3'd4, v); check("wcol set", v[6], 1'b1);
    cyc(1);
    for (int t = 0; t < 300 && !m_int; t++) cyc(1);
    check("wcol xfer done", m_int, 1'b1);
    for (int t = 0; t < 20 && !s_int; t++) cyc(1);
    exp_m_rx = 8'h69;
    exp_s_rx = 8'h96;
    rd(0, 3'd3, v); check("wcol master rx", v, exp_m_rx);
    rd(1, 3'd3, v); check("wcol slave rx", v, exp_s_rx);
    rd(0, 3'd4, v); check("wcol spsr both", v, 8'hC0);
    cyc(1);
    wr(0, 3'd4, 8'h00);
    rd(0, 3'd4, v); check("spsr cleared", v, 8'h00);
    check("int cleared", m_int, 1'b0);
    m_ssn_i = 8'hFF;
    cyc(4);

    // Abort after three SCK periods.
    setup(8'h50, 8'h5A, 8'hC3);
    wr(1, 3'd4, 8'h00);
    m_ssn_i = 8'hFE;
    cyc(1);
    cyc(48);
    m_ssn_i = 8'hFF;
    cyc(8);
    check("abort sck", m_sck, 1'b0);
    rd(0, 3'd4, v); check("abort master spsr", v, 8'h00);
    rd(1, 3'd4, v); check("abort slave spsr", v, 8'h00);
    check("abort ints", {m_int, s_int}, 2'b00);
    rd(0, 3'd3, v); check("abort master rx kept", v, exp_m_rx);
    rd(1, 3'd3, v); check("abort slave rx kept", v, exp_s_rx);
    check("abort misoo", s_miso, 1'b0);
    cyc(1);
    xfer("after abort", 8'h50, 8'($urandom), 8'($urandom));

    // Reset in the middle of a CPOL=1 transfer; slave interrupt is still pending.
    setup(8'h58, 8'h11, 8'h22);
    m_ssn_i = 8'hFE;
    cyc(20);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst spssn_o", m_ssn_o, 8'hFF);
    check("midrst scko", m_sck, 1'b0);
    check("midrst mosio", m_mosi, 1'b0);
    check("midrst ints", {m_int, s_int}, 2'b00);
    rd(0, 3'd0, v); check("midrst spcr", v, 8'h00);
    m_ssn_i = 8'hFF;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
